pipelined_addsub: RTL and testbench



---
 rtl/addsub_pkg.sv | 14 +
 rtl/chunk_adder.sv | 14 +
 rtl/pipelined_addsub.sv | 121 ++++++++++++
 tb/tb_pipelined_addsub.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared opcode encodings and flag layout for the pipelined adder/subtractor.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic overflow;
    logic carry_out;
    logic negative;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple segment: {cout, sum} = a + b + cin.
module chunk_adder #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/subtract: operands are captured, then one CHUNK-bit
// segment is resolved per stage with the carry registered between stages.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  if (WIDTH % CHUNK != 0) begin : g_width_check
    $error("pipelined_addsub: WIDTH must be a multiple of CHUNK");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Entry k holds operands with chunks below k already resolved into s_q[k].
  logic [STAGES:0]   vld_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q;

  logic [CHUNK-1:0]  ch_sum [STAGES];
  logic [STAGES-1:0] ch_cout;
  logic [WIDTH-1:0]  s_nxt [STAGES];

  logic [WIDTH-1:0]  sum_q;
  alu_flags_t        flags_q;
  alu_flags_t        flags_d;

  assign adv      = !vld_q[STAGES] || out_ready;
  assign in_ready = adv;

  // Borrow is folded in as an inverted carry so the chain is always a pure add.
  assign b_eff   = (sub == OP_SUB) ? ~b : b;
  assign cin_eff = (sub == OP_SUB) ? ~carry_in : carry_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    chunk_adder #(
      .W (CHUNK)
    ) u_chunk_adder (
      .a    (a_q[k][CHUNK*k +: CHUNK]),
      .b    (b_q[k][CHUNK*k +: CHUNK]),
      .cin  (c_q[k]),
      .sum  (ch_sum[k]),
      .cout (ch_cout[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nxt[k] = s_q[k];
      s_nxt[k][CHUNK*k +: CHUNK] = ch_sum[k];
    end
  end

  always_comb begin
    flags_d           = '0;
    flags_d.zero      = (s_nxt[STAGES-1] == '0);
    flags_d.negative  = s_nxt[STAGES-1][WIDTH-1];
    flags_d.carry_out = ch_cout[STAGES-1];
    flags_d.overflow  = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                        (s_nxt[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      flags_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q  <= {vld_q[STAGES-1:0], in_valid};
      a_q[0] <= a;
      b_q[0] <= b_eff;
      s_q[0] <= '0;
      c_q[0] <= cin_eff;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
        s_q[k] <= s_nxt[k-1];
        c_q[k] <= ch_cout[k-1];
      end
      sum_q   <= s_nxt[STAGES-1];
      flags_q <= flags_d;
    end
  end

  assign out_valid = vld_q[STAGES];
  assign sum       = sum_q;
  assign carry_out = flags_q.carry_out;
  assign overflow  = flags_q.overflow;
  assign zero      = flags_q.zero;
  assign negative  = flags_q.negative;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: 32/8 and 16/4 instances, directed vectors.
module tb_pipelined_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } exp32_t;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } exp16_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, sub, carry_in, out_valid, out_ready;
  logic        carry_out, overflow, zero, negative;
  logic [31:0] a, b, sum;

  logic        in_valid16, in_ready16, sub16, carry_in16, out_valid16, out_ready16;
  logic        carry_out16, overflow16, zero16, negative16;
  logic [15:0] a16, b16, sum16;

  exp32_t q32[$];
  exp16_t q16[$];
  int checks = 0;
  int errors = 0;

  pipelined_addsub #(
    .WIDTH (32),
    .CHUNK (8)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .zero      (zero),
    .negative  (negative)
  );

  pipelined_addsub #(
    .WIDTH (16),
    .CHUNK (4)
  ) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .a         (a16),
    .b         (b16),
    .sub       (sub16),
    .carry_in  (carry_in16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .sum       (sum16),
    .carry_out (carry_out16),
    .overflow  (overflow16),
    .zero      (zero16),
    .negative  (negative16)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Monitors: pop one expectation for every beat the consumer takes.
  always @(negedge clk) begin
    exp32_t got;
    if (!rst && out_valid && out_ready) begin
      got = {sum, carry_out, overflow, negative, zero};
      if (q32.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat32 unexpected: got %h, expected no beat", got);
      end else begin
        chk("beat32 {sum,c,v,n,z}", got, q32.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    exp16_t got;
    if (!rst && out_valid16 && out_ready16) begin
      got = {sum16, carry_out16, overflow16, negative16, zero16};
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL beat16 unexpected: got %h, expected no beat", got);
      end else begin
        chk("beat16 {sum,c,v,n,z}", got, q16.pop_front());
      end
    end
  end

  task automatic send32(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                        input logic tc, input exp32_t e);
    int n = 0;
    @(negedge clk);
    a = ta; b = tb; sub = ts; carry_in = tc; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) bad("send32 in_ready timeout");
    else q32.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                        input logic tc, input exp16_t e);
    int n = 0;
    @(negedge clk);
    a16 = ta; b16 = tb; sub16 = ts; carry_in16 = tc; in_valid16 = 1'b1;
    while (!in_ready16 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready16) bad("send16 in_ready timeout");
    else q16.push_back(e);
    @(posedge clk);
    #1 in_valid16 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain pending32", q32.size(), 0);
    chk("drain pending16", q16.size(), 0);
  endtask

  // Holds both consumers off, lets three beats reach the output, then resets between edges.
  task automatic reset_midflight(input bit wide);
    int n = 0;
    int stale = 0;
    @(posedge clk);
    #1 out_ready = 1'b0; out_ready16 = 1'b0;
    if (wide) begin
      send32(32'h1, 32'h1, 1'b0, 1'b0, '0);
      send32(32'h2, 32'h2, 1'b0, 1'b0, '0);
      send32(32'h3, 32'h3, 1'b0, 1'b0, '0);
      while (!out_valid && n < 20) begin @(posedge clk); #1 n++; end
    end else begin
      send16(16'h1, 16'h1, 1'b0, 1'b0, '0);
      send16(16'h2, 16'h2, 1'b0, 1'b0, '0);
      send16(16'h3, 16'h3, 1'b0, 1'b0, '0);
      while (!out_valid16 && n < 20) begin @(posedge clk); #1 n++; end
    end
    chk(wide ? "midflight32 reached output" : "midflight16 reached output",
        wide ? out_valid : out_valid16, 1);
    #1 rst = 1'b1;
    #1;
    chk(wide ? "async rst out_valid32" : "async rst out_valid16",
        wide ? out_valid : out_valid16, 0);
    chk(wide ? "async rst sum32" : "async rst sum16", wide ? sum : {16'h0, sum16}, 0);
    q32.delete();
    q16.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1; out_ready16 = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (out_valid || out_valid16) stale++;
    end
    chk(wide ? "stale beats after rst32" : "stale beats after rst16", stale, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; carry_in = 1'b0; out_ready = 1'b1;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; carry_in16 = 1'b0; out_ready16 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid32", out_valid, 0);
    chk("rst sum32", sum, 0);
    chk("rst flags32", {carry_out, overflow, negative, zero}, 0);
    chk("rst out_valid16", out_valid16, 0);
    chk("rst sum16", sum16, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("in_ready32 after release", in_ready, 1);
    chk("in_ready16 after release", in_ready16, 1);

    // Directed arithmetic, back to back.
    send32(32'hFF110000, 32'hF0110000, 1'b0, 1'b0, '{32'hEF220000, 1'b1, 1'b0, 1'b1, 1'b0});
    send32(32'h00000005, 32'h00000007, 1'b1, 1'b0, '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b1, 1'b0});
    send32(32'h00000007, 32'h00000007, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1});
    send32(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, '{32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0});
    send32(32'h80000000, 32'h00000001, 1'b1, 1'b0, '{32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0});
    send32(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1});
    send32(32'h00000010, 32'h00000001, 1'b1, 1'b1, '{32'h0000000E, 1'b1, 1'b0, 1'b0, 1'b0});
    drain();

    // Latency: accepted at edge n, visible after edge n+4.
    send32(32'h00000100, 32'h00000200, 1'b0, 1'b0, '{32'h00000300, 1'b0, 1'b0, 1'b0, 1'b0});
    n = 0;
    do begin
      @(posedge clk);
      #1 n++;
    end while (!out_valid && n < 20);
    chk("latency32 cycles", n, 4);
    drain();

    // Backpressure: six back-to-back beats, consumer stalls three cycles on the first.
    fork
      begin
        send32(32'h00000001, 32'h00000002, 1'b0, 1'b0, '{32'h00000003, 1'b0, 1'b0, 1'b0, 1'b0});
        send32(32'h000000FF, 32'h00000001, 1'b0, 1'b0, '{32'h00000100, 1'b0, 1'b0, 1'b0, 1'b0});
        send32(32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, '{32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0});
        send32(32'h00FFFFFF, 32'h00000001, 1'b0, 1'b1, '{32'h01000001, 1'b0, 1'b0, 1'b0, 1'b0});
        send32(32'h00000000, 32'h00000001, 1'b1, 1'b0, '{32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0});
        send32(32'h12345678, 32'h12345678, 1'b1, 1'b0, '{32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1});
      end
      begin
        int w = 0;
        while (!out_valid && w < 50) begin @(posedge clk); #1 w++; end
        chk("stall first beat present", out_valid, 1);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("stall in_ready", in_ready, 0);
          chk("stall out_valid", out_valid, 1);
          chk("stall sum held", sum, 32'h00000003);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    reset_midflight(1'b1);

    // Narrower parametrisation.
    send16(16'hFFFF, 16'h0000, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    send16(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1, 1'b1, 1'b0});
    send16(16'h0005, 16'h0007, 1'b1, 1'b0, '{16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0});
    send16(16'h1234, 16'h0034, 1'b1, 1'b1, '{16'h11FF, 1'b1, 1'b0, 1'b0, 1'b0});
    drain();

    reset_midflight(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
